// File: rtl/adder_pkg.sv
// adder_pkg: shared helpers for the pipelined carry-lookahead adder.
//   params_ok  - legal WIDTH/SLICE/GROUP combination
//   num_stages - pipeline depth for a given WIDTH/SLICE
package adder_pkg;

    function automatic bit params_ok(input int width, input int slice, input int group);
        return width > 0 && slice > 0 && group > 0 && width % slice == 0 && slice % group == 0;
    endfunction

    function automatic int num_stages(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder built from GROUP-bit groups.
//   a_i, b_i - slice operands
//   c_i      - slice carry in
//   sum_o    - slice sum
//   c_o      - slice carry out
module cla_slice #(
    parameter int SLICE = 8,
    parameter int GROUP = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] sum_o,
    output logic             c_o
);
    localparam int NG = SLICE / GROUP;

    logic [SLICE-1:0] g, p;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;

    assign g   = a_i & b_i;
    assign p   = a_i ^ b_i;
    assign c_o = gc[NG];

    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
    end

    // Each group carry is a flat sum of products over all lower groups and c_i,
    // so nothing ripples from one group into the next.
    always_comb begin : lookahead
        logic t, pp;
        gc    = '0;
        gc[0] = c_i;
        t     = 1'b0;
        pp    = 1'b0;
        for (int j = 0; j < NG; j++) begin
            t  = gg[j];
            pp = gp[j];
            for (int m = j - 1; m >= 0; m--) begin
                t  = t | (pp & gg[m]);
                pp = pp & gp[m];
            end
            gc[j+1] = t | (pp & c_i);
        end
    end

    always_comb begin : sum
        logic cc;
        sum_o = '0;
        cc    = 1'b0;
        for (int j = 0; j < NG; j++) begin
            cc = gc[j];
            for (int i = 0; i < GROUP; i++) begin
                sum_o[j*GROUP+i] = p[j*GROUP+i] ^ cc;
                cc = g[j*GROUP+i] | (p[j*GROUP+i] & cc);
            end
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: elastic skewed-pipeline adder/subtractor, one SLICE per stage.
//   clk_i, rst_i              - clock, synchronous active-high reset
//   a_i, b_i, c_i, sub_i      - operands, carry in, subtract select
//   in_valid_i / in_ready_o   - input handshake
//   sum_o, c_o, v_o, z_o      - result, carry out (1 = no borrow), signed overflow, zero
//   out_valid_o / out_ready_i - output handshake
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int GROUP = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             v_o,
    output logic             z_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int STAGES = num_stages(WIDTH, SLICE);
    localparam int LAST   = STAGES - 1;

    if (!params_ok(WIDTH, SLICE, GROUP)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH %% SLICE and SLICE %% GROUP must both be 0");
    end

    // a_hi/b_hi hold the not-yet-added operand bits, shifted so the next slice
    // sits at the LSBs; sum_lo accumulates the finished low slices in place.
    typedef struct packed {
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    stage_t            st_q [STAGES];
    stage_t            st_d [STAGES];
    logic [STAGES-1:0] valid_q, vin;
    logic [STAGES:0]   adv;
    logic [WIDTH-1:0]  b_eff;
    logic              v_q, z_q, v_d;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign vin   = STAGES'({valid_q, in_valid_i});

    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready_i;
        for (int i = STAGES - 1; i >= 0; i--) adv[i] = !valid_q[i] || adv[i+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        logic [SLICE-1:0] s;
        logic             co;
        if (k == 0) begin : g_first
            assign src = '{a_hi: a_i, b_hi: b_eff, sum_lo: {WIDTH{1'b0}}, carry: c_i ^ sub_i,
                           a_msb: a_i[WIDTH-1], b_msb: b_eff[WIDTH-1]};
        end else begin : g_next
            assign src = st_q[k-1];
        end
        cla_slice #(.SLICE(SLICE), .GROUP(GROUP)) u_slice (
            .a_i  (src.a_hi[SLICE-1:0]),
            .b_i  (src.b_hi[SLICE-1:0]),
            .c_i  (src.carry),
            .sum_o(s),
            .c_o  (co)
        );
        assign st_d[k] = '{a_hi: src.a_hi >> SLICE, b_hi: src.b_hi >> SLICE,
                           sum_lo: src.sum_lo | (WIDTH'(s) << (k * SLICE)), carry: co,
                           a_msb: src.a_msb, b_msb: src.b_msb};
    end

    assign v_d = (st_d[LAST].a_msb == st_d[LAST].b_msb) && (st_d[LAST].sum_lo[WIDTH-1] != st_d[LAST].a_msb);

    // Data only loads with valid data, so bubbles never disturb held outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < STAGES; i++) st_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) valid_q[i] <= vin[i];
                if (adv[i] && vin[i]) st_q[i] <= st_d[i];
            end
            if (adv[LAST] && vin[LAST]) begin
                v_q <= v_d;
                z_q <= ~|st_d[LAST].sum_lo;
            end
        end
    end

    assign in_ready_o  = adv[0];
    assign out_valid_o = valid_q[LAST];
    assign sum_o       = st_q[LAST].sum_lo;
    assign c_o         = st_q[LAST].carry;
    assign v_o         = v_q;
    assign z_o         = z_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed self-checking bench for pipelined_cla_adder.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, cout, v, z, out_valid;
    logic [31:0] sum;
    int          errors = 0;
    int          checks = 0;

    pipelined_cla_adder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .a_i        (a),
        .b_i        (b),
        .c_i        (cin),
        .sub_i      (sub),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .sum_o      (sum),
        .c_o        (cout),
        .v_o        (v),
        .z_o        (z),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain wide arithmetic, flags from their definitions; returns {c, v, z, sum}.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mc, input logic ms);
        logic [31:0] be;
        logic [32:0] r;
        be = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + {32'b0, mc ^ ms};
        return {r[32], (ma[31] == be[31]) && (r[31] != ma[31]), r[31:0] == 32'h0, r[31:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset sum: got %h expected 0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset c_o: got %b expected 0", cout); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset v_o: got %b expected 0", v); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset z_o: got %b expected 0", z); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string name, input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                               input logic ts, input logic [31:0] es, input logic ec, input logic ev, input logic ez);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early out_valid: got %b expected 0", name, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s latency out_valid: got %b expected 1", name, out_valid); end
        checks++; if (sum !== es) begin errors++; $display("FAIL %s sum: got %h expected %h", name, sum, es); end
        checks++; if (cout !== ec) begin errors++; $display("FAIL %s c_o: got %b expected %b", name, cout, ec); end
        checks++; if (v !== ev) begin errors++; $display("FAIL %s v_o: got %b expected %b", name, v, ev); end
        checks++; if (z !== ez) begin errors++; $display("FAIL %s z_o: got %b expected %b", name, z, ez); end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        test_vector("carry_chain",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        test_vector("full_carry",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        test_vector("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        test_vector("add_cin",      32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        test_vector("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        test_vector("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        test_vector("sub_minus1",   32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        test_vector("sub_zero",     32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        test_vector("neg_overflow", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [34:0] q[$];
        logic [34:0] exp;
        int sent = 0, got = 0, gaps = 0;
        bit started = 0;
        out_ready = 1'b1;
        for (int cy = 0; cy < 40 && got < 16; cy++) begin
            if (sent < 16) begin
                a = 32'h9E37_79B9 * (sent + 1);
                b = 32'h7F4A_7C15 ^ (32'(sent) << 20);
                cin = sent[1];
                sub = sent[0];
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (in_valid) begin
                checks++;
                if (in_ready === 1'b1) begin
                    q.push_back(model(a, b, cin, sub));
                    sent++;
                end else begin
                    errors++;
                    $display("FAIL b2b in_ready op %0d: got %b expected 1", sent, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                started = 1;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b unexpected result: got %h expected none", sum);
                end else begin
                    exp = q.pop_front();
                    if ({cout, v, z, sum} !== exp) begin
                        errors++;
                        $display("FAIL b2b result %0d: got %h expected %h", got, {cout, v, z, sum}, exp);
                    end
                end
                got++;
            end else if (started) gaps++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (got != 16) begin errors++; $display("FAIL b2b count: got %0d expected 16", got); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b gaps: got %0d expected 0", gaps); end
    endtask

    task automatic test_backpressure();
        logic [34:0] q[$];
        logic [34:0] held, exp;
        int sent = 0, got = 0, extra = 0, unstable = 0;
        bit have = 0;
        out_ready = 1'b0;
        for (int cy = 0; cy < 10; cy++) begin
            a = 32'h0101_0101 * (sent + 1);
            b = 32'hF0F0_0F0F + 32'(sent);
            cin = 1'b0;
            sub = sent[0];
            in_valid = 1'b1;
            #1;
            if (in_ready === 1'b1) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid === 1'b1) begin
                if (!have) begin
                    held = {cout, v, z, sum};
                    have = 1;
                end else if ({cout, v, z, sum} !== held) unstable++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        checks++; if (sent != 4) begin errors++; $display("FAIL bp accepts: got %0d expected 4", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid: got %b expected 1", out_valid); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp stable: got %0d changes expected 0", unstable); end
        out_ready = 1'b1;
        for (int cy = 0; cy < 12; cy++) begin
            #1;
            if (out_valid === 1'b1) begin
                if (q.size() == 0) extra++;
                else begin
                    exp = q.pop_front();
                    checks++;
                    if ({cout, v, z, sum} !== exp) begin
                        errors++;
                        $display("FAIL bp result %0d: got %h expected %h", got, {cout, v, z, sum}, exp);
                    end
                    got++;
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL bp drained: got %0d expected 4", got); end
        checks++; if (extra != 0) begin errors++; $display("FAIL bp duplicates: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int bad = 0, extra = 0;
        out_ready = 1'b1;
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h3333_3333; b = 32'h4444_4444;
        @(posedge clk); #1;
        rst = 1'b1;
        a = 32'h5555_5555; b = 32'h6666_6666;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b expected 1", in_ready); end
        for (int cy = 0; cy < 8; cy++) begin
            if (out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 || v !== 1'b0 || z !== 1'b0) bad++;
            @(posedge clk); #2;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset quiet: got %0d bad cycles expected 0", bad); end
        test_vector("post_reset", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        for (int cy = 0; cy < 6; cy++) begin
            if (out_valid === 1'b1) extra++;
            @(posedge clk); #1;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midreset extra results: got %0d expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
